// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet TX framer: preamble/SFD, payload fetch, zero pad, FCS append, IFG.
// Talks to an external byte-wide CRC-32 engine (MSB-first register form).
module eth_tx_fcs_ctrl #(
   parameter int MIN_LEN = 60,
   parameter int IFG_LEN = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_start,
   input  logic [10:0] tx_len,
   output logic        tx_req,
   input  logic [7:0]  tx_data,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd,
   output logic        crc_en,
   output logic        crc_clr,
   output logic [7:0]  crc_din,
   input  logic [31:0] crc_data
);

   typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, GAP} state_t;

   localparam logic [11:0] MIN_L    = 12'(MIN_LEN);
   localparam logic [10:0] PAD_LAST = 11'(MIN_LEN > 0 ? MIN_LEN - 1 : 0);
   localparam logic [10:0] GAP_LAST = 11'(IFG_LEN > 0 ? IFG_LEN - 1 : 0);

   state_t      state, state_n;
   logic [10:0] cnt, cnt_n;
   logic [10:0] len_q, len_n;
   logic        en_q, en_n;
   logic [7:0]  txd_q, txd_n;
   logic [10:0] len_last;
   logic        pad_need;
   logic [31:0] crc_inv;
   logic [7:0]  fcs_word;
   logic [7:0]  fcs_byte;

   assign len_last = len_q - 11'd1;
   assign pad_need = {1'b0, len_q} < MIN_L;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         len_q <= '0;
         en_q  <= 1'b0;
         txd_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         len_q <= len_n;
         en_q  <= en_n;
         txd_q <= txd_n;
      end
   end

   // cnt runs on through PAD so PAD ends when the total reaches MIN_LEN
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 11'd1;
      len_n   = len_q;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (tx_start && tx_len != '0) begin
               state_n = PRE;
               len_n   = tx_len;
            end
         end
         PRE: begin
            if (cnt == 11'd7) begin
               state_n = DATA;
               cnt_n   = '0;
            end
         end
         DATA: begin
            if (cnt == len_last) begin
               if (pad_need) begin
                  state_n = PAD;
               end else begin
                  state_n = FCS;
                  cnt_n   = '0;
               end
            end
         end
         PAD: begin
            if (cnt == PAD_LAST) begin
               state_n = FCS;
               cnt_n   = '0;
            end
         end
         FCS: begin
            if (cnt == 11'd3) begin
               state_n = GAP;
               cnt_n   = '0;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // FCS bytes come straight from the engine register, which is frozen here
   always_comb begin
      en_n  = (state_n != IDLE) && (state_n != GAP);
      txd_n = 8'h00;
      if (state_n == PRE) begin
         txd_n = (cnt_n == 11'd7) ? 8'hD5 : 8'h55;
      end else if (state_n == DATA) begin
         txd_n = tx_data;
      end
      crc_inv = ~crc_data;
      unique case (cnt[1:0])
         2'd0:    fcs_word = crc_inv[31:24];
         2'd1:    fcs_word = crc_inv[23:16];
         2'd2:    fcs_word = crc_inv[15:8];
         default: fcs_word = crc_inv[7:0];
      endcase
      for (int i = 0; i < 8; i++) begin
         fcs_byte[i] = fcs_word[7-i];
      end
      gmii_tx_en = en_q;
      gmii_txd   = (state == FCS) ? fcs_byte : txd_q;
      crc_din    = gmii_txd;
      crc_en     = (state == DATA) || (state == PAD);
      crc_clr    = (state == IDLE) || (state == PRE);
      tx_busy    = (state != IDLE);
      tx_done    = (state == GAP) && (cnt == '0);
      tx_req     = ((state == PRE) &&
                    ((cnt == 11'd6) || (cnt == 11'd7 && len_q > 11'd1))) ||
                   ((state == DATA) &&
                    (({1'b0, cnt} + 12'd2) < {1'b0, len_q}));
   end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Bench for eth_tx_fcs_ctrl: two instances (MIN_LEN=0 and default),
// a CRC engine model per instance, an upstream byte source and a scoreboard.
module tb_eth_tx_fcs_ctrl;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       tx_start;
   logic [1:0][10:0] tx_len;
   logic [1:0]       tx_req;
   logic [1:0][7:0]  tx_data;
   logic [1:0]       tx_busy;
   logic [1:0]       tx_done;
   logic [1:0]       gmii_tx_en;
   logic [1:0][7:0]  gmii_txd;
   logic [1:0]       crc_en;
   logic [1:0]       crc_clr;
   logic [1:0][7:0]  crc_din;
   logic [1:0][31:0] crc_data;

   int         errors = 0;
   int         checks = 0;
   int         sel = 1;
   int         pidx = 0;
   bit         pend = 1'b0;
   logic [7:0] pay[$];

   always #5 clk = ~clk;

   eth_tx_fcs_ctrl #(.MIN_LEN(0), .IFG_LEN(12)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .tx_start(tx_start[0]), .tx_len(tx_len[0]),
      .tx_req(tx_req[0]), .tx_data(tx_data[0]),
      .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
      .gmii_tx_en(gmii_tx_en[0]), .gmii_txd(gmii_txd[0]),
      .crc_en(crc_en[0]), .crc_clr(crc_clr[0]),
      .crc_din(crc_din[0]), .crc_data(crc_data[0])
   );

   eth_tx_fcs_ctrl u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .tx_start(tx_start[1]), .tx_len(tx_len[1]),
      .tx_req(tx_req[1]), .tx_data(tx_data[1]),
      .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
      .gmii_tx_en(gmii_tx_en[1]), .gmii_txd(gmii_txd[1]),
      .crc_en(crc_en[1]), .crc_clr(crc_clr[1]),
      .crc_din(crc_din[1]), .crc_data(crc_data[1])
   );

   function automatic logic [31:0] crc_step(input logic [31:0] c,
                                            input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[31] ^ d[i];
         r  = {r[30:0], 1'b0};
         if (fb) r = r ^ 32'h04C11DB7;
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_step(input logic [31:0] c,
                                            input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (crc_clr[u]) crc_data[u] <= 32'hFFFFFFFF;
         else if (crc_en[u]) crc_data[u] <= crc_step(crc_data[u], crc_din[u]);
      end
   end

   // upstream: byte presented the cycle after its request
   initial begin
      forever begin
         @(negedge clk);
         if (pend) begin
            tx_data[sel] = (pidx < pay.size()) ? pay[pidx] : 8'h00;
            pidx++;
         end
         pend = tx_req[sel];
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic run_frame(input int u, input int minlen,
                            input int poke_a, input int poke_b,
                            input int abort_cyc,
                            output int en_cnt, output int cen_cnt,
                            output int done_cyc, output int done_cnt,
                            output int idle_cyc, output int req_first,
                            output int req_last, output int req_cnt,
                            output logic [31:0] fcs_obs,
                            output logic [31:0] resid);
      logic [9:0]  exp[$];
      logic [9:0]  e;
      logic [31:0] rc;
      logic [7:0]  b;
      logic [17:0] got, want;
      int          len, tot, limit;
      len = pay.size();
      tot = (len < minlen) ? minlen : len;
      for (int i = 0; i < 7; i++) exp.push_back({2'b10, 8'h55});
      exp.push_back({2'b10, 8'hD5});
      rc = 32'hFFFFFFFF;
      for (int i = 0; i < tot; i++) begin
         b = (i < len) ? pay[i] : 8'h00;
         exp.push_back({2'b01, b});
         rc = ref_step(rc, b);
      end
      rc = ~rc;
      for (int k = 0; k < 4; k++) exp.push_back({2'b00, rc[8*k +: 8]});
      en_cnt = 0; cen_cnt = 0; done_cyc = -1; done_cnt = 0;
      idle_cyc = -1; req_first = -1; req_last = -1; req_cnt = 0;
      fcs_obs = '0; resid = 32'hFFFFFFFF;
      limit = tot + 60;
      @(negedge clk);
      pidx = 0; pend = 1'b0; sel = u;
      tx_len[u] = 11'(len); tx_start[u] = 1'b1; rst_n = 1'b1;
      for (int cyc = 0; cyc < limit; cyc++) begin
         @(negedge clk);
         tx_start[u] = (cyc == poke_a) || (cyc == poke_b);
         if (tx_start[u]) tx_len[u] = 11'd7;
         if (tx_req[u]) begin
            if (req_first < 0) req_first = cyc;
            req_last = cyc;
            req_cnt++;
         end
         if (crc_en[u]) cen_cnt++;
         if (tx_done[u]) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (gmii_tx_en[u]) begin
            en_cnt++;
            checks++;
            if (exp.size() == 0) begin
               errors++;
               $display("FAIL sb_extra cyc=%0d got=%02h want=none", cyc, gmii_txd[u]);
            end else begin
               e    = exp.pop_front();
               got  = {crc_clr[u], crc_en[u], crc_din[u], gmii_txd[u]};
               want = {e[9:8], e[7:0], e[7:0]};
               if (got !== want) begin
                  errors++;
                  $display("FAIL sb_byte cyc=%0d got=%05h want=%05h", cyc, got, want);
               end
            end
            if (en_cnt > 8) resid = crc_step(resid, gmii_txd[u]);
            fcs_obs = {gmii_txd[u], fcs_obs[31:8]};
         end
         if (cyc == abort_cyc) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if ({gmii_tx_en[u], gmii_txd[u], tx_busy[u]} !== 10'h0) begin
               errors++;
               $display("FAIL async_abort got=%03h want=000",
                        {gmii_tx_en[u], gmii_txd[u], tx_busy[u]});
            end
            break;
         end
         if (!tx_busy[u]) begin
            idle_cyc = cyc;
            break;
         end
      end
      if (abort_cyc < 0) begin
         checks++;
         if (exp.size() != 0) begin
            errors++;
            $display("FAIL sb_left got=%0d want=0", exp.size());
         end
      end
   endtask

   task automatic test_reset();
      logic [21:0] v;
      rst_n = 1'b0;
      tx_start = '0; tx_len = '0; tx_data = '0;
      #23;
      for (int u = 0; u < 2; u++) begin
         v = {gmii_tx_en[u], gmii_txd[u], tx_req[u], tx_busy[u],
              tx_done[u], crc_en[u], crc_clr[u], crc_din[u]};
         checks++;
         if (v !== {1'b0, 8'h00, 4'b0000, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_state u=%0d got=%06h want=%06h", u, v,
                     {1'b0, 8'h00, 4'b0000, 1'b1, 8'h00});
         end
      end
   endtask

   task automatic test_check_vector();
      int en, cen, dc, dn, ic, rf, rl, rn;
      logic [31:0] fo, rs;
      pay.delete();
      for (int i = 1; i <= 9; i++) pay.push_back(8'(8'h30 + i));
      run_frame(0, 0, -1, -1, -1, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      checks++;
      if (fo !== 32'hCBF43926) begin
         errors++; $display("FAIL cv_fcs got=%08h want=CBF43926", fo);
      end
      checks++;
      if (en !== 21) begin
         errors++; $display("FAIL cv_en_len got=%0d want=21", en);
      end
      checks++;
      if (rn !== 9 || rf !== 6) begin
         errors++; $display("FAIL cv_req got=%0d@%0d want=9@6", rn, rf);
      end
      checks++;
      if (cen !== 9) begin
         errors++; $display("FAIL cv_crc_en got=%0d want=9", cen);
      end
      checks++;
      if (dc !== 21 || dn !== 1 || ic !== 33) begin
         errors++; $display("FAIL cv_done got=%0d/%0d/%0d want=21/1/33", dc, dn, ic);
      end
   endtask

   task automatic test_pad();
      int en, cen, dc, dn, ic, rf, rl, rn;
      logic [31:0] fo, rs;
      pay.delete();
      pay.push_back(8'hAB);
      run_frame(1, 60, -1, -1, -1, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      checks++;
      if (rn !== 1 || rf !== 6) begin
         errors++; $display("FAIL pad_req got=%0d@%0d want=1@6", rn, rf);
      end
      checks++;
      if (cen !== 60) begin
         errors++; $display("FAIL pad_crc_en got=%0d want=60", cen);
      end
      checks++;
      if (rs !== 32'hC704DD7B) begin
         errors++; $display("FAIL pad_resid got=%08h want=C704DD7B", rs);
      end
      checks++;
      if (en !== 72 || dc !== 72 || ic !== 84) begin
         errors++; $display("FAIL pad_timing got=%0d/%0d/%0d want=72/72/84", en, dc, ic);
      end
   endtask

   task automatic test_long();
      int en, cen, dc, dn, ic, rf, rl, rn;
      logic [31:0] fo, rs;
      pay.delete();
      for (int i = 0; i < 1500; i++) pay.push_back(8'($urandom_range(0, 255)));
      run_frame(1, 60, -1, -1, -1, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      checks++;
      if (rn !== 1500 || rf !== 6 || rl !== 1505) begin
         errors++; $display("FAIL long_req got=%0d %0d..%0d want=1500 6..1505", rn, rf, rl);
      end
      checks++;
      if (cen !== 1500 || en !== 1512) begin
         errors++; $display("FAIL long_len got=%0d/%0d want=1500/1512", cen, en);
      end
      checks++;
      if (dc !== 1512 || dn !== 1) begin
         errors++; $display("FAIL long_done got=%0d/%0d want=1512/1", dc, dn);
      end
      checks++;
      if (rs !== 32'hC704DD7B) begin
         errors++; $display("FAIL long_resid got=%08h want=C704DD7B", rs);
      end
   endtask

   task automatic test_ignore_start();
      int en, cen, dc, dn, ic, rf, rl, rn;
      logic [31:0] fo, rs;
      pay.delete();
      for (int i = 0; i < 5; i++) pay.push_back(8'(8'hC0 + i));
      run_frame(1, 60, 10, 83, -1, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      checks++;
      if (en !== 72 || dn !== 1 || ic !== 84 || rn !== 5) begin
         errors++;
         $display("FAIL ign_frame got=%0d/%0d/%0d/%0d want=72/1/84/5", en, dn, ic, rn);
      end
      tx_len[1] = 11'd0; tx_start[1] = 1'b1;
      @(negedge clk);
      tx_start[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({gmii_tx_en[1], tx_busy[1]} !== 2'b00) begin
            errors++;
            $display("FAIL ign_len0 got=%02b want=00", {gmii_tx_en[1], tx_busy[1]});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int en, cen, dc, dn, ic, rf, rl, rn;
      logic [31:0] fo, rs;
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(8'(i * 3));
      run_frame(1, 60, -1, -1, -1, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      checks++;
      if (en !== 76 || cen !== 64 || dc !== 76 || ic !== 88) begin
         errors++;
         $display("FAIL b2b_a got=%0d/%0d/%0d/%0d want=76/64/76/88", en, cen, dc, ic);
      end
      pay.delete();
      for (int i = 0; i < 2; i++) pay.push_back(8'(8'h5A + i));
      run_frame(1, 60, -1, -1, -1, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      checks++;
      if (en !== 72 || rn !== 2 || rs !== 32'hC704DD7B) begin
         errors++;
         $display("FAIL b2b_b got=%0d/%0d/%08h want=72/2/C704DD7B", en, rn, rs);
      end
   endtask

   task automatic test_reset_mid();
      int en, cen, dc, dn, ic, rf, rl, rn;
      logic [31:0] fo, rs;
      pay.delete();
      for (int i = 0; i < 100; i++) pay.push_back(8'($urandom_range(0, 255)));
      run_frame(1, 60, -1, -1, 38, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({gmii_tx_en[1], tx_done[1], tx_busy[1]} !== 3'b000) begin
            errors++;
            $display("FAIL abort_quiet got=%03b want=000",
                     {gmii_tx_en[1], tx_done[1], tx_busy[1]});
         end
      end
      checks++;
      if (dn !== 0 || en !== 39) begin
         errors++; $display("FAIL abort_frame got=%0d/%0d want=0/39", dn, en);
      end
      pay.delete();
      for (int i = 0; i < 20; i++) pay.push_back(8'($urandom_range(0, 255)));
      run_frame(1, 60, -1, -1, -1, en, cen, dc, dn, ic, rf, rl, rn, fo, rs);
      checks++;
      if (en !== 72 || dn !== 1 || rs !== 32'hC704DD7B) begin
         errors++;
         $display("FAIL after_abort got=%0d/%0d/%08h want=72/1/C704DD7B", en, dn, rs);
      end
   endtask

   initial begin
      test_reset();
      test_check_vector();
      test_pad();
      test_long();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
